// File: rtl/dir_input_ctrl.sv
// Button front end for the snake core: synchronise, debounce and edge-detect five buttons,
// then filter direction presses into a 2-deep command queue consumed one per game tick.
module dir_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       SYS_CLK,
    input  logic       RST,
    input  logic       UP,
    input  logic       DOWN,
    input  logic       LEFT,
    input  logic       RIGHT,
    input  logic       PAUSE,
    input  logic       game_tick,
    output logic [1:0] cur_dir,
    output logic       paused,
    output logic [1:0] q_count,
    output logic       drop_pulse
);

    localparam int unsigned NB = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit order doubles as the direction code for bits 3:0 (UP=00 .. RIGHT=11).
    logic [NB-1:0]    raw;
    logic [NB-1:0]    sync1;
    logic [NB-1:0]    sync2;
    logic [NB-1:0]    db;
    logic [NB-1:0]    db_prev;
    logic [NB-1:0]    press;
    logic [CNT_W-1:0] cnt [NB];

    logic [1:0] q0;
    logic [1:0] q1;
    logic       push_valid;
    logic [1:0] push_dir;
    logic [1:0] ref_dir;
    logic       pop;
    logic       reject;
    logic       push;

    assign raw   = {PAUSE, RIGHT, LEFT, DOWN, UP};
    assign press = db & ~db_prev;

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            db_prev <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            db_prev <= db;
            for (int unsigned i = 0; i < NB; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        push_valid = 1'b0;
        push_dir   = 2'b00;
        case (press[3:0])
            4'b0001: begin push_valid = 1'b1; push_dir = 2'b00; end
            4'b0010: begin push_valid = 1'b1; push_dir = 2'b01; end
            4'b0100: begin push_valid = 1'b1; push_dir = 2'b10; end
            4'b1000: begin push_valid = 1'b1; push_dir = 2'b11; end
            default: ;
        endcase
        ref_dir = (q_count == 2'd0) ? cur_dir : ((q_count == 2'd1) ? q0 : q1);
        pop     = game_tick & ~paused & (q_count != 2'd0);
        // A full queue still accepts a press when the same-cycle pop frees the head slot.
        reject  = push_valid & ((push_dir[1] == ref_dir[1]) | paused |
                                ((q_count == 2'd2) & ~pop));
        push    = push_valid & ~reject;
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            cur_dir    <= '0;
            paused     <= 1'b0;
            q_count    <= '0;
            drop_pulse <= 1'b0;
            q0         <= '0;
            q1         <= '0;
        end else begin
            drop_pulse <= reject;
            paused     <= paused ^ press[4];
            if (pop) begin
                cur_dir <= q0;
                if (push) begin
                    if (q_count == 2'd1) begin
                        q0 <= push_dir;
                    end else begin
                        q0 <= q1;
                        q1 <= push_dir;
                    end
                end else begin
                    q0      <= q1;
                    q_count <= q_count - 2'd1;
                end
            end else if (push) begin
                if (q_count == 2'd0) begin
                    q0 <= push_dir;
                end else begin
                    q1 <= push_dir;
                end
                q_count <= q_count + 2'd1;
            end
        end
    end

endmodule
